// File: rtl/mcpu_pkg.sv
// Shared constants, opcode map and FSM state type for the MCPU control path.
package mcpu_pkg;

  localparam int WORD_SIZE    = 16;
  localparam int OPCODE_SIZE  = 4;
  localparam int OPERAND_SIZE = 4;
  localparam int ADDR_SIZE    = 8;

  localparam logic [3:0] OP_AND          = 4'd0;
  localparam logic [3:0] OP_OR           = 4'd1;
  localparam logic [3:0] OP_XOR          = 4'd2;
  localparam logic [3:0] OP_NOT          = 4'd3;
  localparam logic [3:0] OP_ADD          = 4'd4;
  localparam logic [3:0] OP_SUB          = 4'd5;
  localparam logic [3:0] OP_LSL          = 4'd6;
  localparam logic [3:0] OP_LSR          = 4'd7;
  localparam logic [3:0] OP_SHORT_TO_REG = 4'd8;
  localparam logic [3:0] OP_LOAD         = 4'd9;
  localparam logic [3:0] OP_STORE        = 4'd10;
  localparam logic [3:0] OP_JMP          = 4'd11;
  localparam logic [3:0] OP_HALT         = 4'd15;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_IMM = 2'd1;
  localparam logic [1:0] WSEL_MEM = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  // ALU ops and SHORT_TO_REG share the EXEC -> WB path.
  function automatic logic is_reg_op(input logic [3:0] op);
    return op <= OP_SHORT_TO_REG;
  endfunction

endpackage

// File: rtl/mcpu_control.sv
// Multi-cycle MCPU control unit: owns PC/IR/MDR and sequences
// fetch, decode, execute, memory and write-back.
module mcpu_control
  import mcpu_pkg::*;
#(
  parameter int WORD_SIZE    = mcpu_pkg::WORD_SIZE,
  parameter int OPCODE_SIZE  = mcpu_pkg::OPCODE_SIZE,
  parameter int OPERAND_SIZE = mcpu_pkg::OPERAND_SIZE,
  parameter int ADDR_SIZE    = mcpu_pkg::ADDR_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WORD_SIZE-1:0]    mem_rdata,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_SIZE-1:0]    mem_addr,
  output logic [OPERAND_SIZE-1:0] rf_ra,
  output logic [OPERAND_SIZE-1:0] rf_rb,
  output logic [OPERAND_SIZE-1:0] rf_wa,
  output logic                    rf_we,
  output logic [1:0]              rf_wsel,
  output logic [OPCODE_SIZE-1:0]  alu_op,
  input  logic [WORD_SIZE-1:0]    rb_data,
  output logic [ADDR_SIZE-1:0]    pc,
  output logic                    halted
);

  state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   pc_q, pc_d;
  logic [WORD_SIZE-1:0]   ir_q, ir_d;
  logic [WORD_SIZE-1:0]   mdr_q, mdr_d;

  logic [OPCODE_SIZE-1:0]  op;
  logic [OPERAND_SIZE-1:0] rd, rs, rt;
  logic [ADDR_SIZE-1:0]    imm;
  logic                    unused_rb_hi;

  assign op  = ir_q[WORD_SIZE-1 -: OPCODE_SIZE];
  assign rd  = ir_q[WORD_SIZE-OPCODE_SIZE-1 -: OPERAND_SIZE];
  assign rs  = ir_q[2*OPERAND_SIZE-1 -: OPERAND_SIZE];
  assign rt  = ir_q[OPERAND_SIZE-1:0];
  assign imm = ir_q[ADDR_SIZE-1:0];

  // Only the low address bits of port B form a RAM address.
  assign unused_rb_hi = ^rb_data[WORD_SIZE-1:ADDR_SIZE];

  always_comb begin
    // NOTE: every variable gets a hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    unique case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_SIZE'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_reg_op(op) || op == OP_JMP)       state_d = ST_EXEC;
        else if (op == OP_LOAD || op == OP_STORE) state_d = ST_MEM;
        else if (op == OP_HALT)                   state_d = ST_HALT;
        else                                      state_d = ST_FETCH;
      end
      ST_EXEC: begin
        if (op == OP_JMP) begin
          pc_d    = imm;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (op == OP_STORE) begin
            state_d = ST_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = ST_WB;
          end
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all state registers update together at the edge.
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
    end
  end

  // NOTE: strobes are masked by reset so nothing is requested or written in the reset cycle.
  always_comb begin
    mem_req  = !reset && (state_q == ST_FETCH || state_q == ST_MEM);
    mem_we   = !reset && (state_q == ST_MEM) && (op == OP_STORE);
    mem_addr = (state_q == ST_MEM) ? rb_data[ADDR_SIZE-1:0] : pc_q;
    rf_ra    = (state_q == ST_MEM && op == OP_STORE) ? rd : rs;
    rf_rb    = rt;
    rf_wa    = rd;
    rf_we    = !reset && (state_q == ST_WB);
    if (op == OP_SHORT_TO_REG)  rf_wsel = WSEL_IMM;
    else if (op == OP_LOAD)     rf_wsel = WSEL_MEM;
    else                        rf_wsel = WSEL_ALU;
    alu_op   = op;
    pc       = pc_q;
    halted   = !reset && (state_q == ST_HALT);
  end

endmodule

// File: tb/tb_mcpu_control.sv
// Directed bench for mcpu_control with a small RAM, register file and ALU model around it.
module tb_mcpu_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_we, rf_we, halted;
  logic [7:0]  mem_addr, pc;
  logic [3:0]  rf_ra, rf_rb, rf_wa, alu_op;
  logic [1:0]  rf_wsel;
  logic [15:0] rb_data;

  logic [15:0] ram [256];
  logic [15:0] rf  [16];
  logic [15:0] rdata_hold;
  logic [15:0] wdata, alu_y, ra_v, rb_v;

  logic        ld_clr = 1'b0, ld_rf_en = 1'b0, ld_ram_en = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mcpu_control dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .alu_op(alu_op), .rb_data(rb_data), .pc(pc), .halted(halted)
  );

  assign ra_v      = rf[rf_ra];
  assign rb_v      = rf[rf_rb];
  assign rb_data   = rb_v;
  assign mem_rdata = (mem_req && !mem_we) ? ram[mem_addr] : rdata_hold;

  always_comb begin
    alu_y = '0;
    case (alu_op)
      4'd0: alu_y = ra_v & rb_v;
      4'd1: alu_y = ra_v | rb_v;
      4'd2: alu_y = ra_v ^ rb_v;
      4'd3: alu_y = ~ra_v;
      4'd4: alu_y = ra_v + rb_v;
      4'd5: alu_y = ra_v - rb_v;
      4'd6: alu_y = ra_v << rb_v[3:0];
      4'd7: alu_y = ra_v >> rb_v[3:0];
      default: alu_y = '0;
    endcase
    wdata = alu_y;
    if (rf_wsel == 2'd1)      wdata = {8'h00, rf_ra, rf_rb};
    else if (rf_wsel == 2'd2) wdata = mem_rdata;
  end

  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      for (int i = 0; i < 16; i++)  rf[i]  <= '0;
      rdata_hold <= '0;
    end else begin
      if (ld_rf_en)   rf[ld_addr[3:0]] <= ld_data;
      else if (rf_we) rf[rf_wa] <= wdata;
      if (ld_ram_en)  ram[ld_addr] <= ld_data;
      else if (mem_req && mem_we && mem_ready) ram[mem_addr] <= ra_v;
      if (mem_req && !mem_we && mem_ready) rdata_hold <= ram[mem_addr];
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic begin_test();
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    ld_clr = 1'b1;
    @(posedge clk);
    #1 ld_clr = 1'b0;
  endtask

  task automatic load_ram(input logic [7:0] a, input logic [15:0] d);
    ld_ram_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1 ld_ram_en = 1'b0;
  endtask

  task automatic load_rf(input logic [3:0] a, input logic [15:0] d);
    ld_rf_en = 1'b1; ld_addr = {4'h0, a}; ld_data = d;
    @(posedge clk);
    #1 ld_rf_en = 1'b0;
  endtask

  // Leaves the bench at the sample point of cycle 1 (first FETCH cycle).
  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    begin_test();
    step(); step();
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc: got %h want 00", pc); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b want 0", halted); end
    release_reset();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || mem_we !== 1'b0) begin
      failures++; $display("FAIL reset_first_fetch: got req=%b we=%b addr=%h want req=1 we=0 addr=00", mem_req, mem_we, mem_addr);
    end
  endtask

  task automatic test_program();
    int n_we;
    int we_cyc [4];
    begin_test();
    load_ram(8'd0, 16'h8E02);
    load_ram(8'd1, 16'h8F03);
    load_ram(8'd2, 16'h651E);
    load_ram(8'd3, 16'h761F);
    load_ram(8'd4, 16'hF000);
    load_rf(4'd1, 16'h12CC);
    release_reset();
    n_we = 0;
    for (int k = 1; k <= 24; k++) begin
      if (rf_we === 1'b1) begin
        if (n_we < 4) we_cyc[n_we] = k;
        n_we++;
      end
      step();
    end
    checks++; if (n_we != 4) begin failures++; $display("FAIL prog_we_count: got %0d want 4", n_we); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (n_we > i && we_cyc[i] != 4 * (i + 1)) begin
        failures++; $display("FAIL prog_we_cycle%0d: got %0d want %0d", i, we_cyc[i], 4 * (i + 1));
      end
    end
    checks++; if (rf[5] !== 16'h4B30) begin failures++; $display("FAIL prog_r5: got %h want 4b30", rf[5]); end
    checks++; if (rf[6] !== 16'h0259) begin failures++; $display("FAIL prog_r6: got %h want 0259", rf[6]); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL prog_halted: got %b want 1", halted); end
  endtask

  task automatic test_wait_states();
    int first_we;
    logic stable_ok;
    begin_test();
    load_ram(8'd0, 16'h81AB);
    load_ram(8'd1, 16'hF000);
    release_reset();
    first_we = 0;
    stable_ok = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      mem_ready = (k >= 4);
      if (k <= 4 && (mem_addr !== 8'h00 || pc !== 8'h00 || mem_req !== 1'b1)) stable_ok = 1'b0;
      if (k == 5) begin
        checks++; if (pc !== 8'h01) begin failures++; $display("FAIL wait_pc_inc: got %h want 01", pc); end
      end
      if (rf_we === 1'b1 && first_we == 0) first_we = k;
      step();
    end
    checks++; if (!stable_ok) begin failures++; $display("FAIL wait_fetch_stable: got unstable addr/pc want addr=00 pc=00"); end
    checks++; if (first_we != 7) begin failures++; $display("FAIL wait_latency: got %0d want 7", first_we); end
    checks++; if (rf[1] !== 16'h00AB) begin failures++; $display("FAIL wait_r1: got %h want 00ab", rf[1]); end
  endtask

  task automatic test_store_load();
    int n_mwe, mwe_cyc, we_cyc;
    logic load_ok;
    begin_test();
    load_ram(8'd0, 16'hA203);
    load_ram(8'd1, 16'h9403);
    load_ram(8'd2, 16'hF000);
    load_rf(4'd2, 16'hBEEF);
    load_rf(4'd3, 16'h0040);
    release_reset();
    n_mwe = 0; mwe_cyc = 0; we_cyc = 0; load_ok = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      mem_ready = (k != 6);
      if (mem_we === 1'b1) begin
        n_mwe++; mwe_cyc = k;
        checks++; if (mem_addr !== 8'h40) begin failures++; $display("FAIL store_addr: got %h want 40", mem_addr); end
      end
      if ((k == 6 || k == 7) && (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h40)) load_ok = 1'b0;
      if (rf_we === 1'b1) begin
        we_cyc = k;
        checks++; if (rf_wsel !== 2'd2) begin failures++; $display("FAIL load_wsel: got %0d want 2", rf_wsel); end
      end
      step();
    end
    checks++; if (n_mwe != 1 || mwe_cyc != 3) begin failures++; $display("FAIL store_we_pulse: got count=%0d cycle=%0d want count=1 cycle=3", n_mwe, mwe_cyc); end
    checks++; if (!load_ok) begin failures++; $display("FAIL load_mem_stall: got unstable req/we/addr want req=1 we=0 addr=40"); end
    checks++; if (we_cyc != 8) begin failures++; $display("FAIL load_wb_cycle: got %0d want 8", we_cyc); end
    checks++; if (ram[8'h40] !== 16'hBEEF) begin failures++; $display("FAIL store_data: got %h want beef", ram[8'h40]); end
    checks++; if (rf[4] !== 16'hBEEF) begin failures++; $display("FAIL load_r4: got %h want beef", rf[4]); end
  endtask

  task automatic test_jmp_wrap();
    int halt_cyc;
    logic quiet;
    begin_test();
    load_ram(8'd0, 16'h820F);
    load_ram(8'd1, 16'h830C);
    load_ram(8'd2, 16'h6423);
    load_ram(8'd3, 16'h8500);
    load_ram(8'd4, 16'hA405);
    load_ram(8'd5, 16'hB0FF);
    load_ram(8'hFF, 16'h8107);
    release_reset();
    halt_cyc = 0; quiet = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 23) begin
        checks++; if (mem_addr !== 8'hFF || pc !== 8'hFF || mem_req !== 1'b1) begin
          failures++; $display("FAIL jmp_target_fetch: got addr=%h pc=%h req=%b want addr=ff pc=ff req=1", mem_addr, pc, mem_req);
        end
      end
      if (k == 24) begin
        checks++; if (pc !== 8'h00) begin failures++; $display("FAIL jmp_pc_wrap: got %h want 00", pc); end
      end
      if (halted === 1'b1 && halt_cyc == 0) halt_cyc = k;
      if (halt_cyc != 0 && mem_req !== 1'b0) quiet = 1'b0;
      step();
    end
    checks++; if (halt_cyc != 29) begin failures++; $display("FAIL jmp_halt_cycle: got %0d want 29", halt_cyc); end
    checks++; if (rf[1] !== 16'h0007) begin failures++; $display("FAIL jmp_r1: got %h want 0007", rf[1]); end
    checks++; if (ram[0] !== 16'hF000) begin failures++; $display("FAIL jmp_halt_store: got %h want f000", ram[0]); end
    checks++; if (!quiet || halted !== 1'b1) begin failures++; $display("FAIL halt_absorb: got quiet=%b halted=%b want quiet=1 halted=1", quiet, halted); end
  endtask

  task automatic test_reset_mid_wb();
    begin_test();
    load_ram(8'd0, 16'h4123);
    load_rf(4'd2, 16'h0003);
    load_rf(4'd3, 16'h0004);
    release_reset();
    step(); step(); step();
    checks++; if (rf_we !== 1'b1 || rf_wsel !== 2'd0 || alu_op !== 4'd4) begin
      failures++; $display("FAIL add_wb: got we=%b wsel=%0d op=%0d want we=1 wsel=0 op=4", rf_we, rf_wsel, alu_op);
    end
    reset = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0 || mem_req !== 1'b0) begin
      failures++; $display("FAIL rst_wb_cycle: got we=%b req=%b want we=0 req=0", rf_we, mem_req);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0 || mem_we !== 1'b0) begin
      failures++; $display("FAIL rst_after_we: got rf_we=%b mem_we=%b want 0 0", rf_we, mem_we);
    end
    checks++; if (pc !== 8'h00 || mem_req !== 1'b1 || mem_addr !== 8'h00) begin
      failures++; $display("FAIL rst_after_fetch: got pc=%h req=%b addr=%h want pc=00 req=1 addr=00", pc, mem_req, mem_addr);
    end
  endtask

  task automatic test_nop();
    logic quiet;
    begin_test();
    load_ram(8'd0, 16'hB005);
    load_ram(8'd5, 16'hD000);
    load_ram(8'd6, 16'hF000);
    release_reset();
    quiet = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 4) begin
        checks++; if (mem_addr !== 8'h05 || mem_req !== 1'b1) begin
          failures++; $display("FAIL nop_fetch: got addr=%h req=%b want addr=05 req=1", mem_addr, mem_req);
        end
      end
      if (k == 5) begin
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL nop_decode_req: got %b want 0", mem_req); end
      end
      if ((k == 4 || k == 5) && (rf_we !== 1'b0 || mem_we !== 1'b0)) quiet = 1'b0;
      if (k == 6) begin
        checks++; if (pc !== 8'h06 || mem_addr !== 8'h06 || mem_req !== 1'b1) begin
          failures++; $display("FAIL nop_next_fetch: got pc=%h addr=%h req=%b want pc=06 addr=06 req=1", pc, mem_addr, mem_req);
        end
      end
      step();
    end
    checks++; if (!quiet) begin failures++; $display("FAIL nop_quiet: got write strobe want none"); end
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    test_reset();
    test_program();
    test_wait_states();
    test_store_load();
    test_jmp_wrap();
    test_reset_mid_wb();
    test_nop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcpu_control.md
# mcpu_control

Multi-cycle control unit for MCPU. It owns the program counter and instruction register, and sequences every instruction through fetch, decode, execute, memory and write-back. It drives the RAM handshake, register-file read/write controls and ALU opcode, and it sits between the RAM, register-file and ALU datapath at the top level of MCPU.

## Interface

Parameters:
- WORD_SIZE, 16, instruction/data word width
- OPCODE_SIZE, 4, opcode field width
- OPERAND_SIZE, 4, register-index field width (16 registers)
- ADDR_SIZE, 8, RAM address width (RAM_SIZE = 256)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- mem_rdata  in  WORD_SIZE  RAM read data, valid when mem_ready=1
- mem_ready  in  1  RAM completes current request this cycle
- mem_req  out  1  RAM request strobe, held until mem_ready
- mem_we  out  1  write request (with mem_req)
- mem_addr  out  ADDR_SIZE  RAM address
- rf_ra, rf_rb  out  OPERAND_SIZE  register-file read indices (IR[7:4], IR[3:0])
- rf_wa  out  OPERAND_SIZE  write index (IR[11:8])
- rf_we  out  1  register-file write enable
- rf_wsel  out  2  write-data select: 0 ALU, 1 imm8 zero-extended, 2 mem_rdata
- alu_op  out  OPCODE_SIZE  ALU operation (IR[15:12])
- rb_data  in  WORD_SIZE  register-file port-B read value (memory address source)
- pc  out  ADDR_SIZE  program counter
- halted  out  1  high in HALT state

## Operation

- Instruction format: {op, rd, rs, rt} or {op, rd, imm8}.
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 SUB, 6 LSL, 7 LSR, 8 SHORT_TO_REG, 9 LOAD (rd <= mem[rb_data[7:0]]), 10 STORE (mem[rb_data[7:0]] <= rd), 11 JMP (pc <= imm8), 15 HALT. Opcodes 12–14 are NOPs.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready, IR <= mem_rdata, pc <= pc+1 (mod 256, wraps 255→0), go to DECODE.
  - DECODE: opcodes 0–8 go to EXEC. 9 and 10 go to MEM. 11 goes to EXEC. 15 goes to HALT. NOPs go to FETCH.
  - EXEC: opcodes 0–8 go to WB. For 11, pc <= IR[7:0], then go to FETCH.
  - MEM: mem_req=1, mem_addr=rb_data[7:0], mem_we=(op==10); for STORE, rf_ra = rd field. On mem_ready: LOAD goes to WB with mem_rdata captured in MDR; STORE goes to FETCH.
  - WB: rf_we=1 for exactly one cycle, rf_wsel selected by opcode (8→1, 9→2, else 0), rf_wa=IR[11:8]. Then go to FETCH.
  - HALT: absorbing state; only reset leaves it.
- Outputs are Moore-decoded from state and IR; mem_req/mem_we/rf_we are never asserted outside the states listed.

## Timing

- Reset values: state FETCH, pc 0, IR 0, MDR 0, mem_req 0 during the reset cycle, mem_we 0, rf_we 0, halted 0.
- Reset mid-instruction: the next cycle is FETCH at pc 0. No rf_we and no mem_we is issued in the cycle after reset.
- Latency with zero wait states (mem_ready tied high):
  - ALU/SHORT_TO_REG: 4 cycles.
  - LOAD: 4 cycles.
  - STORE: 3 cycles.
  - JMP: 3 cycles.
  - NOP: 2 cycles.
- Each RAM wait cycle (mem_req=1, mem_ready=0) stalls FETCH/MEM by one cycle with mem_addr/mem_we stable.
- mem_ready sampled outside FETCH/MEM is ignored.

## Structure

- Shared package mcpu_pkg holds:
  - WORD_SIZE, OPCODE_SIZE, OPERAND_SIZE, ADDR_SIZE constants
  - OP_* opcode constants
  - state enum typedef
  - rf_wsel encodings
- Single module; no sub-module. The FSM next-state logic and the PC/IR/MDR registers live in the same file.

## Test plan

- Program at mem[0..3] = {8,E,02}, {8,F,03}, {6,5,1,E}, {7,6,1,F}, R1=16'h12CC, mem_ready=1. Required: R5=16'h4B30, R6=16'h0259, with rf_we pulses at cycles 4, 8, 12, 16 after reset release.
- mem_ready low for 3 cycles during FETCH of pc=0. Required: mem_addr stays 0, pc increments only after mem_ready, total latency = 7 cycles.
- STORE R2 (=16'hBEEF) to address held in R3 (=8'h40), then LOAD R4 from R3. Required: mem_we high exactly one cycle with addr 8'h40, and R4=16'hBEEF.
- JMP 8'hFF with mem[255] = {8,1,07} and mem[0] = HALT. Required: R1=7, pc wraps to 0, halted=1, and no further mem_req.
- Reset asserted during WB of an ADD. Required: no rf_we in the cycle after reset, pc=0, state FETCH.
- Opcode 13 at pc=5. Required: a 2-cycle NOP with no rf_we and no mem_we, and pc=6 at the next FETCH.
